alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001: Parameter: `BUS_WIDTH, 3, data MSB index; data width D = `BUS_WIDTH+1 = 4 bits, signed two's complement.
REQ-002: One clock; reset is synchronous and active-high.
REQ-003: clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004: reset_in  input  1  synchronous active-high reset.
REQ-005: instr_valid_in  input  1  instruction word is valid.
REQ-006: instr_ready_out  output  1  sequencer accepts an instruction this cycle.
REQ-007: instr_in  input  16  [15:8] opcode, [7:6] rd, [5:4] rs1, [3:0] rs2 index ([1:0]) or signed immediate.
REQ-008: alu_enable_out  output  1  ALU enable.
REQ-009: alu_opcode_out  output  8  opcode driven to the ALU.
REQ-010: alu_input1_out, alu_input2_out  output  D each  signed ALU operands.
REQ-011: alu_output_in  input  D  ALU result.
REQ-012: overflow_in, carry_in, zero_in, sign_in, parity_in  input  1 each  ALU flags.
REQ-013: result_valid_out  output  1  one-cycle pulse on register writeback.
REQ-014: result_out  output  D  value written; result_reg_out  output  2  destination index.
REQ-015: flags_out  output  5  registered {overflow, carry, zero, sign, parity}.
REQ-016: illegal_op_out  output  1  one-cycle pulse on rejected opcode.
REQ-017: reg_read_addr_in  input  2 / reg_read_data_out  output  D  combinational debug read of the register file.

Function
REQ-018: The block SHALL hold four D-bit registers r0-r3, all writable.
REQ-019: Legal opcodes SHALL be 8'h00 ADD, 8'h01 SUB, 8'h03 EQUALS, 8'h04 GREATER_THAN, 8'h09 ADDI, 8'h0A SUBI, 8'h0B MOV; all others, including 8'h02, SHALL be illegal.
REQ-020: FSM states SHALL be IDLE, ISSUE, WRITEBACK.
REQ-021: IDLE: instr_ready_out=1; on valid&ready, latch instr_in and go to ISSUE; otherwise stay in IDLE.
REQ-022: ISSUE: instr_ready_out=0, alu_enable_out=1, alu_opcode_out=latched opcode, alu_input1_out=r[rs1], alu_input2_out=imm[3:0] for ADDI/SUBI, else r[rs2]; MOV drives r[rs1] on input1; at the clock edge, capture alu_output_in and all five flags, then go to WRITEBACK.
REQ-023: WRITEBACK: write captured result to r[rd]; update flags_out; assert result_valid_out, result_out and result_reg_out for exactly this cycle; go to IDLE.
REQ-024: An illegal opcode SHALL NOT enable the ALU; the FSM SHALL go IDLE->IDLE, pulse illegal_op_out one cycle after acceptance, and leave registers and flags_out unchanged.
REQ-025: Latency SHALL be acceptance at edge N, result_valid_out high in cycle N+2, and next acceptance no earlier than edge N+3; throughput is one instruction per 3 cycles.
REQ-026: Outside ISSUE, alu_enable_out, alu_opcode_out and both operands SHALL be 0.
REQ-027: rd==rs1 or rd==rs2 SHALL read pre-write values; no bypass is needed because each writeback completes before the next acceptance.
REQ-028: instr_in SHALL be ignored while instr_ready_out=0; a held instr_valid_in SHALL be accepted on the first IDLE cycle.
REQ-029: Immediate is sign-extended as 4-bit signed; no width extension because D=4.
REQ-030: reg_read_data_out SHALL reflect r[reg_read_addr_in] combinationally, including the value written the previous edge.

Reset
REQ-031: When reset_in=1 at an edge, the FSM SHALL go to IDLE, r0-r3=0, flags_out=0, and result_out, result_reg_out, result_valid_out and illegal_op_out=0.
REQ-032: Reset in ISSUE or WRITEBACK SHALL drop the instruction with no writeback and no result_valid_out pulse.
REQ-033: instr_ready_out SHALL be 0 during a reset cycle and 1 in the first cycle after reset deasserts.

Verification (bench has the ALU attached)
REQ-034: After reset, ADDI r1,r0,#5 then ADDI r2,r0,#3 -> r1=5, r2=3; flags_out after r2 write = 5'b00000.
REQ-035: ADD r3,r1,r2 -> result_out=4'b1000 (-8), result_reg_out=3, flags_out=5'b10011 (overflow, sign, parity).
REQ-036: SUBI r0,r0,#1 from r0=0 -> r0=4'b1111, flags_out=5'b00010; GREATER_THAN r0,r1,r3 (5>-8) -> r0=1.
REQ-037: Opcode 8'h02 with valid held -> illegal_op_out pulses once, alu_enable_out stays 0, registers and flags unchanged, next instruction accepted the cycle after.
REQ-038: instr_valid_in held high continuously -> instr_ready_out pattern 1,0,0 repeats; each instruction yields exactly one result_valid_out pulse 2 cycles after acceptance.
REQ-039: reset_in asserted during ISSUE of ADDI r1,r0,#7 -> no result_valid_out pulse, r1=0, FSM in IDLE with instr_ready_out=1 after reset deasserts.

Source files
------------

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer: fetches one instruction, drives an external ALU
// for one cycle, then writes the captured result into a four-entry signed register file.
module alu_sequencer #(
    parameter int BUS_WIDTH = 3
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        instr_valid_in,
    output logic                        instr_ready_out,
    input  logic [15:0]                 instr_in,
    output logic                        alu_enable_out,
    output logic [7:0]                  alu_opcode_out,
    output logic signed [BUS_WIDTH:0]   alu_input1_out,
    output logic signed [BUS_WIDTH:0]   alu_input2_out,
    input  logic signed [BUS_WIDTH:0]   alu_output_in,
    input  logic                        overflow_in,
    input  logic                        carry_in,
    input  logic                        zero_in,
    input  logic                        sign_in,
    input  logic                        parity_in,
    output logic                        result_valid_out,
    output logic signed [BUS_WIDTH:0]   result_out,
    output logic [1:0]                  result_reg_out,
    output logic [4:0]                  flags_out,
    output logic                        illegal_op_out,
    input  logic [1:0]                  reg_read_addr_in,
    output logic signed [BUS_WIDTH:0]   reg_read_data_out
);

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_EQ   = 8'h03;
    localparam logic [7:0] OP_GT   = 8'h04;
    localparam logic [7:0] OP_ADDI = 8'h09;
    localparam logic [7:0] OP_SUBI = 8'h0A;
    localparam logic [7:0] OP_MOV  = 8'h0B;

    typedef enum logic [1:0] {IDLE, ISSUE, WRITEBACK} state_t;

    function automatic logic is_legal(input logic [7:0] op);
        return op inside {OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_ADDI, OP_SUBI, OP_MOV};
    endfunction

    function automatic logic uses_imm(input logic [7:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    state_t                      state;
    logic signed [BUS_WIDTH:0]   regs [4];
    logic [1:0]                  rd_p0;
    logic [4:0]                  flags_p1;
    logic                        vld_p1;

    logic [7:0]                  op_dec;
    logic [1:0]                  rd_dec;
    logic [1:0]                  rs1_dec;
    logic [1:0]                  rs2_dec;
    logic signed [BUS_WIDTH:0]   imm_dec;

    assign op_dec  = instr_in[15:8];
    assign rd_dec  = instr_in[7:6];
    assign rs1_dec = instr_in[5:4];
    assign rs2_dec = instr_in[1:0];
    assign imm_dec = (BUS_WIDTH+1)'($signed(instr_in[3:0]));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            rd_p0          <= '0;
            flags_p1       <= '0;
            vld_p1         <= 1'b0;
            alu_enable_out <= 1'b0;
            alu_opcode_out <= '0;
            alu_input1_out <= '0;
            alu_input2_out <= '0;
            result_out     <= '0;
            result_reg_out <= '0;
            flags_out      <= '0;
            illegal_op_out <= 1'b0;
        end else begin
            illegal_op_out <= 1'b0;
            case (state)
                // p0: accept and decode; operands read from the register file here
                IDLE: begin
                    if (instr_valid_in) begin
                        if (is_legal(op_dec)) begin
                            state          <= ISSUE;
                            alu_enable_out <= 1'b1;
                            alu_opcode_out <= op_dec;
                            alu_input1_out <= regs[rs1_dec];
                            alu_input2_out <= uses_imm(op_dec) ? imm_dec : regs[rs2_dec];
                            rd_p0          <= rd_dec;
                        end else begin
                            illegal_op_out <= 1'b1;
                        end
                    end
                end
                // p1: ALU result and flags captured at the end of the issue cycle
                ISSUE: begin
                    state          <= WRITEBACK;
                    alu_enable_out <= 1'b0;
                    alu_opcode_out <= '0;
                    alu_input1_out <= '0;
                    alu_input2_out <= '0;
                    result_out     <= alu_output_in;
                    result_reg_out <= rd_p0;
                    flags_p1       <= {overflow_in, carry_in, zero_in, sign_in, parity_in};
                    vld_p1         <= 1'b1;
                end
                // p2: commit, so the next accepted instruction already sees the new value
                WRITEBACK: begin
                    state                <= IDLE;
                    regs[result_reg_out] <= result_out;
                    flags_out            <= flags_p1;
                    vld_p1               <= 1'b0;
                    result_out           <= '0;
                    result_reg_out       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset arriving during writeback kills the commit, so it also hides the pulse.
    assign instr_ready_out   = (state == IDLE) && !reset_in;
    assign result_valid_out  = vld_p1 && !reset_in;
    assign reg_read_data_out = regs[reg_read_addr_in];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: attaches a behavioural ALU, drives directed and random
// instructions, and compares every cycle against a transaction-level register model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [15:0] instr_in;
    logic        alu_enable_out;
    logic [7:0]  alu_opcode_out;
    logic [3:0]  alu_input1_out;
    logic [3:0]  alu_input2_out;
    logic [3:0]  alu_output_in;
    logic        overflow_in, carry_in, zero_in, sign_in, parity_in;
    logic        result_valid_out;
    logic [3:0]  result_out;
    logic [1:0]  result_reg_out;
    logic [4:0]  flags_out;
    logic        illegal_op_out;
    logic [1:0]  reg_read_addr_in;
    logic [3:0]  reg_read_data_out;

    alu_sequencer #(.BUS_WIDTH(3)) dut (
        .clk_in(clk), .reset_in(reset_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out), .instr_in(instr_in),
        .alu_enable_out(alu_enable_out), .alu_opcode_out(alu_opcode_out),
        .alu_input1_out(alu_input1_out), .alu_input2_out(alu_input2_out),
        .alu_output_in(alu_output_in), .overflow_in(overflow_in), .carry_in(carry_in),
        .zero_in(zero_in), .sign_in(sign_in), .parity_in(parity_in),
        .result_valid_out(result_valid_out), .result_out(result_out),
        .result_reg_out(result_reg_out), .flags_out(flags_out), .illegal_op_out(illegal_op_out),
        .reg_read_addr_in(reg_read_addr_in), .reg_read_data_out(reg_read_data_out)
    );

    // ALU: {result[3:0], overflow, carry, zero, sign, parity} from plain integer arithmetic
    function automatic logic [8:0] alu_calc(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r;
        logic ov, cy;
        logic [3:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        ov = 1'b0;
        cy = 1'b0;
        r  = 0;
        case (op)
            8'h00, 8'h09: begin r = sa + sb; ov = (r > 7) || (r < -8); cy = (ua + ub) > 15; end
            8'h01, 8'h0A: begin r = sa - sb; ov = (r > 7) || (r < -8); cy = (ua >= ub); end
            8'h03: r = (sa == sb) ? 1 : 0;
            8'h04: r = (sa > sb) ? 1 : 0;
            8'h0B: r = sa;
            default: r = 0;
        endcase
        res = r[3:0];
        return {res, ov, cy, (res == 4'd0), res[3], ^res};
    endfunction

    function automatic bit legal_op(input logic [7:0] op);
        return op inside {8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B};
    endfunction

    logic [8:0] alu_word;
    always_comb begin
        alu_word = alu_calc(alu_opcode_out, alu_input1_out, alu_input2_out);
        if (!alu_enable_out) alu_word = 9'b0101_11111;
    end
    assign alu_output_in = alu_word[8:5];
    assign {overflow_in, carry_in, zero_in, sign_in, parity_in} = alu_word[4:0];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural registers plus the cycle numbers of pending events
    logic [3:0] m_reg [4];
    logic [4:0] m_flags;
    int         cyc, free_cyc, wb_cyc, ill_cyc;
    logic [7:0] p_op;
    logic [3:0] p_a, p_b, p_res;
    logic [1:0] p_rd;
    logic [4:0] p_flags;
    int         acc_q[$];
    int         rv_seen, ill_seen;
    logic [3:0] last_res;
    logic [1:0] last_rd;
    logic [15:0] stream_q[$];

    task automatic cycle();
        bit exp_ready, exp_issue, exp_rv;
        logic [8:0] w;
        logic [7:0] op;
        reg_read_addr_in = 2'($urandom);
        @(negedge clk);
        exp_ready = !reset_in && (cyc >= free_cyc);
        exp_issue = (cyc == wb_cyc - 1);
        exp_rv    = (cyc == wb_cyc) && !reset_in;
        chk("ready", 16'(instr_ready_out), 16'(exp_ready));
        chk("alu_en", 16'(alu_enable_out), 16'(exp_issue));
        chk("alu_op", 16'(alu_opcode_out), exp_issue ? 16'(p_op) : 16'h0);
        chk("alu_in1", 16'(alu_input1_out), exp_issue ? 16'(p_a) : 16'h0);
        chk("alu_in2", 16'(alu_input2_out), exp_issue ? 16'(p_b) : 16'h0);
        chk("res_valid", 16'(result_valid_out), 16'(exp_rv));
        chk("res_data", 16'(result_out), (cyc == wb_cyc) ? 16'(p_res) : 16'h0);
        chk("res_reg", 16'(result_reg_out), (cyc == wb_cyc) ? 16'(p_rd) : 16'h0);
        chk("illegal", 16'(illegal_op_out), 16'(cyc == ill_cyc));
        chk("flags", 16'(flags_out), 16'(m_flags));
        chk("reg_read", 16'(reg_read_data_out), 16'(m_reg[reg_read_addr_in]));
        if (result_valid_out) begin
            rv_seen++;
            last_res = result_out;
            last_rd  = result_reg_out;
        end
        if (illegal_op_out) ill_seen++;
        if (reset_in) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
            m_flags  = 5'd0;
            wb_cyc   = -10;
            ill_cyc  = -10;
            free_cyc = cyc + 1;
        end else begin
            if (cyc == wb_cyc) begin
                m_reg[p_rd] = p_res;
                m_flags     = p_flags;
            end
            if (instr_valid_in && exp_ready) begin
                acc_q.push_back(cyc);
                op = instr_in[15:8];
                if (legal_op(op)) begin
                    p_op  = op;
                    p_rd  = instr_in[7:6];
                    p_a   = m_reg[instr_in[5:4]];
                    p_b   = (op == 8'h09 || op == 8'h0A) ? instr_in[3:0] : m_reg[instr_in[1:0]];
                    w     = alu_calc(p_op, p_a, p_b);
                    p_res = w[8:5];
                    p_flags = w[4:0];
                    wb_cyc   = cyc + 2;
                    free_cyc = cyc + 3;
                end else begin
                    ill_cyc  = cyc + 1;
                    free_cyc = cyc + 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins);
        int n0;
        n0 = acc_q.size();
        instr_valid_in = 1'b1;
        instr_in = ins;
        for (int k = 0; k < 8 && acc_q.size() == n0; k++) cycle();
        instr_valid_in = 1'b0;
        instr_in = 16'h0;
        chk("send_accept", 16'(acc_q.size()), 16'(n0 + 1));
        repeat (4) cycle();
    endtask

    task automatic run_stream();
        int k;
        k = 0;
        instr_valid_in = 1'b1;
        while (stream_q.size() > 0 && k < 100) begin
            int n0;
            n0 = acc_q.size();
            instr_in = stream_q[0];
            cycle();
            if (acc_q.size() != n0) void'(stream_q.pop_front());
            k++;
        end
        instr_valid_in = 1'b0;
        chk("stream_drain", 16'(stream_q.size()), 16'h0);
        repeat (3) cycle();
    endtask

    task automatic peek(input logic [1:0] a, input logic [3:0] e, input string tag);
        reg_read_addr_in = a;
        #1;
        chk(tag, 16'(reg_read_data_out), 16'(e));
    endtask

    function automatic logic [15:0] rand_instr(input bit legal_only);
        logic [7:0] ops [7];
        logic [7:0] op;
        ops = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B};
        op = (legal_only || $urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 6)] : 8'($urandom);
        return {op, 8'($urandom)};
    endfunction

    initial begin
        int base, rv0, ill0;
        cyc = 0; free_cyc = 0; wb_cyc = -10; ill_cyc = -10;
        for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
        m_flags = 5'd0; p_op = 0; p_a = 0; p_b = 0; p_res = 0; p_rd = 0; p_flags = 0;
        rv_seen = 0; ill_seen = 0; last_res = 0; last_rd = 0;
        reset_in = 1'b1; instr_valid_in = 1'b0; instr_in = 16'h0; reg_read_addr_in = 2'd0;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        reset_in = 1'b0;
        cycle();

        send({8'h09, 2'd1, 2'd0, 4'd5});
        send({8'h09, 2'd2, 2'd0, 4'd3});
        peek(2'd1, 4'd5, "addi_r1");
        peek(2'd2, 4'd3, "addi_r2");
        chk("addi_flags", 16'(flags_out), 16'h00);

        send({8'h00, 2'd3, 2'd1, 4'd2});
        chk("add_result", 16'(last_res), 16'h8);
        chk("add_rd", 16'(last_rd), 16'h3);
        chk("add_flags", 16'(flags_out), 16'(5'b10011));

        send({8'h0A, 2'd0, 2'd0, 4'd1});
        peek(2'd0, 4'hF, "subi_r0");
        chk("subi_flags", 16'(flags_out), 16'(5'b00010));
        send({8'h04, 2'd0, 2'd1, 4'd3});
        peek(2'd0, 4'd1, "gt_r0");

        // illegal opcode held valid, followed straight away by a MOV
        base = acc_q.size(); rv0 = rv_seen; ill0 = ill_seen;
        stream_q = '{{8'h02, 2'd1, 2'd2, 4'd3}, {8'h0B, 2'd2, 2'd3, 4'd0}};
        run_stream();
        chk("illegal_pulses", 16'(ill_seen - ill0), 16'h1);
        chk("illegal_next_acc", 16'(acc_q[base + 1] - acc_q[base]), 16'h1);
        chk("illegal_rv", 16'(rv_seen - rv0), 16'h1);
        peek(2'd2, 4'h8, "mov_r2");

        // continuous valid: one acceptance every three cycles
        base = acc_q.size(); rv0 = rv_seen;
        for (int i = 0; i < 4; i++) stream_q.push_back(rand_instr(1'b1));
        run_stream();
        for (int i = 1; i < 4; i++) chk("b2b_gap", 16'(acc_q[base + i] - acc_q[base + i - 1]), 16'h3);
        chk("b2b_rv", 16'(rv_seen - rv0), 16'h4);

        for (int i = 0; i < 150; i++) begin
            instr_valid_in = ($urandom_range(0, 3) != 0);
            instr_in = rand_instr(1'b0);
            cycle();
        end
        instr_valid_in = 1'b0;
        repeat (4) cycle();

        // reset during ISSUE (ph=1) and during WRITEBACK (ph=2) of ADDI r1,r0,#7
        for (int ph = 1; ph <= 2; ph++) begin
            int n0;
            rv0 = rv_seen;
            n0 = acc_q.size();
            instr_valid_in = 1'b1;
            instr_in = {8'h09, 2'd1, 2'd0, 4'd7};
            for (int k = 0; k < 8 && acc_q.size() == n0; k++) cycle();
            instr_valid_in = 1'b0;
            if (ph == 2) cycle();
            reset_in = 1'b1;
            cycle();
            reset_in = 1'b0;
            repeat (3) cycle();
            chk("rst_drop_rv", 16'(rv_seen - rv0), 16'h0);
            peek(2'd1, 4'd0, "rst_drop_r1");
            chk("rst_ready", 16'(instr_ready_out), 16'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
